// File: rtl/cpu_ctrl_pkg.sv
// Shared types and widths for the processor step controller.
// Holds the controller state encoding and the divider/tap bus widths.
package cpu_ctrl_pkg;

   localparam int DIV_W = 32;
   localparam int TAP_W = 5;

   typedef enum logic [1:0] {
      HALT      = 2'd0,
      RUN       = 2'd1,
      STEP_WAIT = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/cpu_step_ctrl_sync_edge.sv
// Multi-stage synchronizer for an asynchronous level input followed by a
// rising-edge detector; a held input yields a single one-clock rise.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic [STAGES-1:0] sync_r;
   logic              level_q;

   // Synchronizer chain plus one delayed copy of the synchronized level.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_r  <= '0;
         level_q <= 1'b0;
      end else begin
         sync_r  <= {sync_r[STAGES-2:0], din};
         level_q <= sync_r[STAGES-1];
      end
   end

   assign rise = sync_r[STAGES-1] & ~level_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Generates the processor clock-enable from a selectable divider tap, with
// run, halt and pushbutton single-step modes and an issued-cycle counter.
module cpu_step_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [DIV_W-1:0] divided_clocks,
   input  logic [TAP_W-1:0] tap_sel,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_btn,
   output logic             cpu_en,
   output logic             tick,
   output logic [1:0]       mode,
   output logic [CNT_W-1:0] cpu_cycles
);

   ctrl_state_t      state;
   ctrl_state_t      state_next;
   logic             tap;
   logic             tap_q;
   logic [TAP_W-1:0] sel_q;
   logic             tap_edge;
   logic             step_rise;
   logic             cpu_en_next;

   assign tap      = divided_clocks[tap_sel];
   // A mux switch can look like a rise; only trust edges on a stable select.
   assign tap_edge = tap & ~tap_q & (tap_sel == sel_q);

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_step_sync (
      .clock (clock),
      .reset (reset),
      .din   (step_btn),
      .rise  (step_rise)
   );

   // Remember last tap level and select for edge qualification.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tap_q <= 1'b0;
         sel_q <= '0;
      end else begin
         tap_q <= tap;
         sel_q <= tap_sel;
      end
   end

   // Next-state and enable decode; halt_req wins over everything.
   always_comb begin
      state_next  = state;
      cpu_en_next = 1'b0;
      case (state)
         HALT: begin
            if (halt_req) begin
               state_next = HALT;
            end else if (run_req) begin
               state_next = RUN;
            end else if (step_rise) begin
               state_next = STEP_WAIT;
            end else begin
               state_next = HALT;
            end
         end
         RUN: begin
            if (halt_req || !run_req) begin
               state_next = HALT;
            end else begin
               state_next  = RUN;
               cpu_en_next = tap_edge;
            end
         end
         STEP_WAIT: begin
            if (halt_req) begin
               state_next = HALT;
            end else if (tap_edge) begin
               state_next  = HALT;
               cpu_en_next = 1'b1;
            end else begin
               state_next = STEP_WAIT;
            end
         end
         default: begin
            state_next = HALT;
         end
      endcase
   end

   // State, registered pulses and the wrapping issued-cycle counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= HALT;
         cpu_en     <= 1'b0;
         tick       <= 1'b0;
         cpu_cycles <= '0;
      end else begin
         state      <= state_next;
         cpu_en     <= cpu_en_next;
         tick       <= tap_edge;
         cpu_cycles <= cpu_cycles + {{(CNT_W-1){1'b0}}, cpu_en};
      end
   end

   assign mode = state;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomized and directed bench for cpu_step_ctrl against a behavioural
// model built from the tap-rise, step and priority rules.
module tb_cpu_step_ctrl;

   localparam int CNT_W = 4;
   localparam int SYNC  = 2;

   logic             clock = 1'b0;
   logic             reset;
   logic [31:0]      divided_clocks;
   logic [4:0]       tap_sel;
   logic             run_req;
   logic             halt_req;
   logic             step_btn;
   logic             cpu_en;
   logic             tick;
   logic [1:0]       mode;
   logic [CNT_W-1:0] cpu_cycles;

   always #5 clock = ~clock;

   cpu_step_ctrl #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .divided_clocks (divided_clocks),
      .tap_sel        (tap_sel),
      .run_req        (run_req),
      .halt_req       (halt_req),
      .step_btn       (step_btn),
      .cpu_en         (cpu_en),
      .tick           (tick),
      .mode           (mode),
      .cpu_cycles     (cpu_cycles)
   );

   int          n_vec = 0;
   int          n_bad = 0;
   int unsigned cnt;
   int          m_state;      // 0 halted, 1 running, 2 waiting for step tap
   bit          m_en;
   bit          m_tick;
   int          m_cycles;
   bit          m_prev_tap;
   int          m_prev_sel;
   bit          hist[$];      // step_btn as seen at past clock edges, newest first
   int          dut_pulses;
   int          mdl_pulses;
   bit          prev_dut_en;
   logic [CNT_W-1:0] c0;
   logic [CNT_W-1:0] diff;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state    = 0;
      m_en       = 1'b0;
      m_tick     = 1'b0;
      m_cycles   = 0;
      m_prev_tap = 1'b0;
      m_prev_sel = 0;
      hist.delete();
      for (int i = 0; i <= SYNC; i++) hist.push_back(1'b0);
   endtask

   // Predict the effect of the coming clock edge from the current inputs.
   task automatic model_step();
      bit tap_now;
      bit rose;
      bit press;
      int nxt;
      bit en_n;
      tap_now = ((cnt >> tap_sel) & 32'd1) != 32'd0;
      rose    = (int'(tap_sel) == m_prev_sel) && tap_now && !m_prev_tap;
      press   = hist[SYNC-1] && !hist[SYNC];
      nxt     = m_state;
      en_n    = 1'b0;
      if (halt_req) nxt = 0;
      else if (m_state == 0) nxt = run_req ? 1 : (press ? 2 : 0);
      else if (m_state == 1) begin
         if (!run_req) nxt = 0;
         else en_n = rose;
      end else if (m_state == 2 && rose) begin
         nxt  = 0;
         en_n = 1'b1;
      end
      m_cycles   = (m_cycles + int'(m_en)) % (1 << CNT_W);
      m_en       = en_n;
      m_tick     = rose;
      m_state    = nxt;
      m_prev_tap = tap_now;
      m_prev_sel = int'(tap_sel);
      hist.push_front(step_btn);
      void'(hist.pop_back());
   endtask

   task automatic tick_cycle();
      model_step();
      @(posedge clock);
      @(negedge clock);
      check_val("cpu_en", cpu_en, m_en);
      check_val("tick", tick, m_tick);
      check_val("mode", mode, m_state);
      check_val("cpu_cycles", cpu_cycles, m_cycles);
      check_val("en_back_to_back", cpu_en & prev_dut_en, 0);
      dut_pulses  += int'(cpu_en);
      mdl_pulses  += int'(m_en);
      prev_dut_en  = cpu_en;
      cnt++;
      divided_clocks = cnt;
   endtask

   initial begin
      reset = 1'b0; tap_sel = 5'd0; run_req = 1'b0; halt_req = 1'b0; step_btn = 1'b0;
      cnt = 0; divided_clocks = 32'd0; prev_dut_en = 1'b0;
      dut_pulses = 0; mdl_pulses = 0;
      model_reset();
      #2 reset = 1'b1;
      #1;
      check_val("rst_cpu_en", cpu_en, 0);
      check_val("rst_tick", tick, 0);
      check_val("rst_mode", mode, 0);
      check_val("rst_cycles", cpu_cycles, 0);
      @(negedge clock);
      reset = 1'b0;

      // Idle with divider running.
      dut_pulses = 0;
      repeat (50) tick_cycle();
      check_val("idle_pulses", dut_pulses, 0);

      // Continuous run at tap 2.
      tap_sel = 5'd2; run_req = 1'b1; dut_pulses = 0;
      repeat (64) tick_cycle();
      check_val("run_tap2_pulses", (dut_pulses >= 7 && dut_pulses <= 8), 1);

      // Two single-step presses at tap 3.
      run_req = 1'b0; tap_sel = 5'd3;
      repeat (3) tick_cycle();
      for (int p = 1; p <= 2; p++) begin
         dut_pulses = 0; c0 = cpu_cycles;
         step_btn = 1'b1;
         repeat (20) tick_cycle();
         step_btn = 1'b0;
         repeat (10) tick_cycle();
         check_val("step_pulses", dut_pulses, 1);
         diff = cpu_cycles - c0;
         check_val("step_count", diff, 1);
         check_val("step_mode", mode, 0);
      end

      // Halt in the same cycle as a tap rise at tap 0.
      tap_sel = 5'd0; run_req = 1'b1;
      repeat (4) tick_cycle();
      for (int i = 0; i < 4 && (cnt & 32'd1) == 32'd0; i++) tick_cycle();
      halt_req = 1'b1; dut_pulses = 0;
      repeat (2) tick_cycle();
      check_val("halt_edge_pulses", dut_pulses, 0);
      halt_req = 1'b0;

      // Switch tap 0 -> 4 while bit 4 is high and bit 0 was low.
      repeat (2) tick_cycle();
      for (int i = 0; i < 64 && !(((cnt >> 4) & 32'd1) == 32'd1 && (cnt & 32'd1) == 32'd1); i++)
         tick_cycle();
      tap_sel = 5'd4; dut_pulses = 0; mdl_pulses = 0;
      tick_cycle();
      check_val("switch_no_pulse", cpu_en, 0);
      repeat (80) tick_cycle();
      check_val("tap4_pulses", dut_pulses, mdl_pulses);

      // Wrap the narrow counter at tap 0.
      tap_sel = 5'd0; dut_pulses = 0;
      repeat (34) tick_cycle();
      check_val("wrap_pulses", (dut_pulses >= 16 && dut_pulses <= 17), 1);

      // Asynchronous reset while a pulse is high.
      for (int i = 0; i < 10 && cpu_en !== 1'b1; i++) tick_cycle();
      check_val("found_pulse", cpu_en, 1);
      #1 reset = 1'b1;
      #1;
      check_val("midrst_cpu_en", cpu_en, 0);
      check_val("midrst_tick", tick, 0);
      check_val("midrst_mode", mode, 0);
      check_val("midrst_cycles", cpu_cycles, 0);
      model_reset();
      run_req = 1'b0; prev_dut_en = 1'b0;
      @(negedge clock);
      reset = 1'b0;

      // Randomized mix of run, halt, tap changes and button activity.
      dut_pulses = 0; mdl_pulses = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(99, 0) < 5) run_req = ~run_req;
         halt_req = ($urandom_range(99, 0) < 3);
         if ($urandom_range(99, 0) < 3) tap_sel = 5'($urandom_range(4, 0));
         if ($urandom_range(99, 0) < 4) step_btn = ~step_btn;
         tick_cycle();
      end
      check_val("random_pulses", dut_pulses, mdl_pulses);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Sits directly downstream of the free-running clock divider. Consumes its 32-bit divided_clocks bus.
- Produces a one-cycle clock-enable pulse (cpu_en) that advances the single-cycle processor. The processor therefore runs on the base clock with an enable, never on a derived clock.
- Supports three modes: continuous run at a selectable divider tap, halt, and single-step from a pushbutton.
- Keeps a count of issued processor cycles for debug display.

Parameters:
- CNT_W, 16, width of cpu_cycles counter.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous step_btn input (minimum 2).

Ports:
- clock  input  1  base clock; same clock that drives the divider.
- reset  input  1  asynchronous, active-high reset.
- divided_clocks  input  32  divider output bus; bit k rises once every 2^(k+1) clocks.
- tap_sel  input  5  index of the divided_clocks bit used as the run rate.
- run_req  input  1  level; 1 = run continuously.
- halt_req  input  1  level; 1 = force halt, overrides everything.
- step_btn  input  1  asynchronous pushbutton; each press = one processor cycle while halted.
- cpu_en  output  1  one-clock enable pulse to the processor.
- tick  output  1  registered pulse; selected tap rose (debug/LED).
- mode  output  2  current FSM state encoding.
- cpu_cycles  output  CNT_W  number of cpu_en pulses issued since reset; wraps.

Behaviour:
- Reset (async, active-high): state=HALT, cpu_en=0, tick=0, cpu_cycles=0, tap_q=0, sel_q=0, synchronizer and step_q flops=0. Outputs go to these values immediately on reset assertion, not at the next clock.
- Tap select and edge detect:
  - tap = divided_clocks[tap_sel]; tap_q <= tap every clock; sel_q <= tap_sel every clock.
  - edge = tap & ~tap_q & (tap_sel == sel_q). A change of tap_sel suppresses edge for that cycle, which prevents a false edge from the mux switch.
  - tick <= edge, so tick lags the first clock tap is sampled high by 1 cycle.
- Step input:
  - step_btn passes through SYNC_STAGES flops to give step_s; step_q <= step_s.
  - step_rise = step_s & ~step_q.
  - Held button = one step only. Latency from button high to step_rise is SYNC_STAGES+1 clocks.
- FSM states: HALT=2'd0, RUN=2'd1, STEP_WAIT=2'd2. 2'd3 is illegal and recovers to HALT on the next clock.
  - HALT:
    - halt_req → stay.
    - else run_req → RUN.
    - else step_rise → STEP_WAIT.
  - RUN:
    - halt_req or !run_req → HALT.
    - step_rise is ignored.
  - STEP_WAIT:
    - halt_req → HALT, no pulse.
    - else edge → HALT with pulse.
    - run_req is ignored until the step completes.
- cpu_en (registered) <= edge & ~halt_req & (state==RUN | state==STEP_WAIT). Exactly one cpu_en per accepted step.
- Simultaneous events:
  - halt_req has highest priority, then run_req, then step_rise.
  - If edge occurs in the same cycle RUN exits because run_req drops, no pulse is issued.
- cpu_cycles increments by 1 in the cycle after each cpu_en=1. It wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-pulse: cpu_en drops immediately; any pending step is discarded.
- cpu_en is never high two consecutive clocks, including at tap_sel=0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - typedef enum logic [1:0] {HALT, RUN, STEP_WAIT} ctrl_state_t;
  - localparam DIV_W=32, TAP_W=5.
- One natural sub-module: sync_edge (parameterized synchronizer + rising-edge detector). It is used for step_btn and reusable for other board buttons.

Test Plan:
- Reset → mode=0, cpu_en=0, cpu_cycles=0; hold run_req=0 for 50 clocks with divider running → zero cpu_en pulses.
- tap_sel=2, run_req=1 for 64 clocks → cpu_en every 8 clocks, 1 clock wide; cpu_cycles=8 (±1 for alignment).
- run_req=0 and step_btn high for 20 clocks at tap_sel=3 → exactly one cpu_en within 16+SYNC_STAGES+2 clocks of press; mode returns to 0; cpu_cycles=1. Second press → cpu_cycles=2.
- RUN at tap_sel=0, then assert halt_req in the same cycle as a tap rise → no cpu_en issued; mode=0 next clock.
- Change tap_sel 0→4 while tap bit 4=1 and the prior tap bit was 0 → no cpu_en in the switch cycle; next pulse aligns to bit-4 rise, then every 32 clocks.
- CNT_W=4, RUN at tap_sel=0 for 34 clocks → cpu_cycles wraps 15→0 and reads 1 after 17 pulses; assert reset mid-run → all outputs 0 immediately without a clock edge.
